mem_port_arbiter: RTL and testbench

//  Shares one single-ported unified memory between the fetch path (PC/IF_ID, read-only) and the data path (EX_MEM/MEM, read/write).

---
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between the fetch path and the data path.
// Optional watchdog abort is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W          = 32,
   parameter int unsigned DATA_W          = 32,
   parameter int unsigned MAX_DATA_STREAK = 4,
   parameter int unsigned TIMEOUT_CYCLES  = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_done,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_done,
   output logic              stall_if,
   output logic              stall_d,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              timeout_err
);

   typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D, DONE} state_t;

   localparam logic [7:0] STREAK_MAX = 8'(MAX_DATA_STREAK);

   generate
      if (MAX_DATA_STREAK < 1 || MAX_DATA_STREAK > 255 ||
          TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
         $error("mem_port_arbiter: parameter out of legal range");
      end
   endgenerate

   state_t            state, state_next;
   logic              grant_if, grant_d, busy, timeout, finish;
   logic [7:0]        streak;
   logic              owner_d;
   logic [DATA_W-1:0] rdata_q;

   assign busy   = (state == BUSY_IF) || (state == BUSY_D);
   assign finish = busy && (mem_ack || timeout);

`ifdef MEM_ARB_TIMEOUT_EN
   localparam logic [15:0] WDOG_LIMIT = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] wdog;
   logic        timeout_q;

   // Ack on the limit edge takes priority, so timeout only fires without ack.
   assign timeout = busy && !mem_ack && (wdog == WDOG_LIMIT);

   always_ff @(posedge clk) begin
      if (!rst) begin
         wdog      <= '0;
         timeout_q <= 1'b0;
      end else begin
         wdog <= busy ? wdog + 16'd1 : '0;
         if (finish)
            timeout_q <= timeout;
      end
   end

   assign timeout_err = (state == DONE) && timeout_q;
`else
   assign timeout     = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Data wins a tie until it has taken STREAK_MAX grants in a row over a waiting fetch.
   always_comb begin
      state_next = state;
      grant_if   = 1'b0;
      grant_d    = 1'b0;
      case (state)
         IDLE: begin
            if (d_req && !(if_req && streak == STREAK_MAX)) begin
               grant_d    = 1'b1;
               state_next = BUSY_D;
            end else if (if_req) begin
               grant_if   = 1'b1;
               state_next = BUSY_IF;
            end
         end
         BUSY_IF, BUSY_D: begin
            if (finish)
               state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         streak <= '0;
      end else if (state == IDLE) begin
         if (grant_if || !if_req)
            streak <= '0;
         else if (grant_d && streak != STREAK_MAX)
            streak <= streak + 8'd1;
      end
   end

   // Memory-side request registers stay frozen for the whole access.
   always_ff @(posedge clk) begin
      if (!rst) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         owner_d   <= 1'b0;
         rdata_q   <= '0;
      end else if (grant_d) begin
         mem_req   <= 1'b1;
         mem_we    <= d_we;
         mem_addr  <= d_addr;
         mem_wdata <= d_wdata;
         owner_d   <= 1'b1;
      end else if (grant_if) begin
         mem_req   <= 1'b1;
         mem_we    <= 1'b0;
         mem_addr  <= if_addr;
         mem_wdata <= '0;
         owner_d   <= 1'b0;
      end else if (finish) begin
         mem_req <= 1'b0;
         rdata_q <= (mem_ack && !mem_we) ? mem_rdata : '0;
      end
   end

   assign if_done  = (state == DONE) && !owner_d;
   assign d_done   = (state == DONE) && owner_d;
   assign if_rdata = if_done ? rdata_q : '0;
   assign d_rdata  = d_done ? rdata_q : '0;
   assign stall_if = if_req && !if_done;
   assign stall_d  = d_req && !d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: per-cycle vector table plus directed multi-cycle sequences.
module tb_mem_port_arbiter;

   localparam logic H = 1'b1;
   localparam logic L = 1'b0;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        if_req, d_req, d_we;
   logic [31:0] if_addr, d_addr, d_wdata;
   logic [31:0] if_rdata, d_rdata;
   logic        if_done, d_done, stall_if, stall_d;
   logic        mem_req, mem_we, mem_ack, timeout_err;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   logic        auto_mem = 1'b0;
   logic        tb_ack = 1'b0;
   logic [31:0] tb_rdata = '0;

   // Zero-wait memory model returns a word derived from the address it was given.
   assign mem_ack   = auto_mem ? mem_req : tb_ack;
   assign mem_rdata = auto_mem ? (mem_addr ^ 32'hA5A5_0000) : tb_rdata;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .MAX_DATA_STREAK(4), .TIMEOUT_CYCLES(8)
   ) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_done(d_done),
      .stall_if(stall_if), .stall_d(stall_d),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .timeout_err(timeout_err)
   );

   typedef struct {
      logic        if_req;
      logic [31:0] if_addr;
      logic        d_req;
      logic        d_we;
      logic [31:0] d_addr;
      logic [31:0] d_wdata;
      logic        ack;
      logic [31:0] rdata;
      logic        x_mem_req;
      logic        x_mem_we;
      logic [31:0] x_mem_addr;
      logic [31:0] x_mem_wdata;
      logic        x_if_done;
      logic        x_d_done;
      logic [31:0] x_rdata;
      logic        x_stall_if;
      logic        x_stall_d;
   } vec_t;

   vec_t vecs[16];
   int   compared   = 0;
   int   mismatched = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      if_req  = L;
      if_addr = '0;
      d_req   = L;
      d_we    = L;
      d_addr  = '0;
      d_wdata = '0;
      tb_ack  = L;
      tb_rdata = '0;
   endtask

   task automatic do_reset();
      drive_idle();
      auto_mem = L;
      rst = L;
      step();
      step();
      @(negedge clk);
      check("reset mem_req", 32'(mem_req), 32'(L));
      check("reset if_done", 32'(if_done), 32'(L));
      check("reset d_done", 32'(d_done), 32'(L));
      check("reset mem_addr", mem_addr, 32'h0);
      check("reset timeout_err", 32'(timeout_err), 32'(L));
      step();
      rst = H;
   endtask

   task automatic apply_stimulus(input vec_t v);
      if_req   = v.if_req;
      if_addr  = v.if_addr;
      d_req    = v.d_req;
      d_we     = v.d_we;
      d_addr   = v.d_addr;
      d_wdata  = v.d_wdata;
      tb_ack   = v.ack;
      tb_rdata = v.rdata;
   endtask

   task automatic check_output(input int idx, input vec_t v);
      string tag;
      tag = $sformatf("vec%0d", idx);
      check({tag, " mem_req"}, 32'(mem_req), 32'(v.x_mem_req));
      check({tag, " if_done"}, 32'(if_done), 32'(v.x_if_done));
      check({tag, " d_done"}, 32'(d_done), 32'(v.x_d_done));
      check({tag, " stall_if"}, 32'(stall_if), 32'(v.x_stall_if));
      check({tag, " stall_d"}, 32'(stall_d), 32'(v.x_stall_d));
      check({tag, " timeout_err"}, 32'(timeout_err), 32'(L));
      if (v.x_mem_req) begin
         check({tag, " mem_we"}, 32'(mem_we), 32'(v.x_mem_we));
         check({tag, " mem_addr"}, mem_addr, v.x_mem_addr);
         if (v.x_mem_we)
            check({tag, " mem_wdata"}, mem_wdata, v.x_mem_wdata);
      end
      if (v.x_if_done)
         check({tag, " if_rdata"}, if_rdata, v.x_rdata);
      if (v.x_d_done)
         check({tag, " d_rdata"}, d_rdata, v.x_rdata);
   endtask

   initial begin
      string order, exp_order;
      int    cycles, busy_cycles;
      logic  seen_done;

      // inputs: if_req if_addr d_req d_we d_addr d_wdata ack rdata | expected: mem_req mem_we mem_addr mem_wdata if_done d_done rdata stall_if stall_d
      vecs[0]  = '{H, 32'h100, L, L, 32'h0,  32'h0,         L, 32'h0,         L, L, 32'h0,  32'h0,         L, L, 32'h0,         H, L};
      vecs[1]  = '{H, 32'h100, L, L, 32'h0,  32'h0,         H, 32'h2402_0005, H, L, 32'h100, 32'h0,        L, L, 32'h0,         H, L};
      vecs[2]  = '{L, 32'h0,   L, L, 32'h0,  32'h0,         L, 32'h0,         L, L, 32'h0,  32'h0,         H, L, 32'h2402_0005, L, L};
      vecs[3]  = '{L, 32'h0,   L, L, 32'h0,  32'h0,         L, 32'h0,         L, L, 32'h0,  32'h0,         L, L, 32'h0,         L, L};
      vecs[4]  = '{L, 32'h0,   H, H, 32'h40, 32'hDEAD_BEEF, L, 32'h0,         L, L, 32'h0,  32'h0,         L, L, 32'h0,         L, H};
      vecs[5]  = '{L, 32'h0,   H, H, 32'h40, 32'hDEAD_BEEF, L, 32'h0,         H, H, 32'h40, 32'hDEAD_BEEF, L, L, 32'h0,         L, H};
      vecs[6]  = '{L, 32'h0,   H, H, 32'h99, 32'h0,         L, 32'h0,         H, H, 32'h40, 32'hDEAD_BEEF, L, L, 32'h0,         L, H};
      vecs[7]  = '{L, 32'h0,   H, H, 32'h40, 32'hDEAD_BEEF, L, 32'h0,         H, H, 32'h40, 32'hDEAD_BEEF, L, L, 32'h0,         L, H};
      vecs[8]  = '{L, 32'h0,   H, H, 32'h40, 32'hDEAD_BEEF, H, 32'h5555_5555, H, H, 32'h40, 32'hDEAD_BEEF, L, L, 32'h0,         L, H};
      vecs[9]  = '{L, 32'h0,   L, L, 32'h0,  32'h0,         L, 32'h0,         L, L, 32'h0,  32'h0,         L, H, 32'h0,         L, L};
      vecs[10] = '{L, 32'h0,   L, L, 32'h0,  32'h0,         H, 32'hFFFF_FFFF, L, L, 32'h0,  32'h0,         L, L, 32'h0,         L, L};
      vecs[11] = '{L, 32'h0,   L, L, 32'h0,  32'h0,         L, 32'h0,         L, L, 32'h0,  32'h0,         L, L, 32'h0,         L, L};
      vecs[12] = '{L, 32'h0,   H, L, 32'h44, 32'h0,         L, 32'h0,         L, L, 32'h0,  32'h0,         L, L, 32'h0,         L, H};
      vecs[13] = '{L, 32'h0,   H, L, 32'h44, 32'h0,         H, 32'h1234_5678, H, L, 32'h44, 32'h0,         L, L, 32'h0,         L, H};
      vecs[14] = '{L, 32'h0,   L, L, 32'h0,  32'h0,         H, 32'hCAFE_0000, L, L, 32'h0,  32'h0,         L, H, 32'h1234_5678, L, L};
      vecs[15] = '{L, 32'h0,   L, L, 32'h0,  32'h0,         L, 32'h0,         L, L, 32'h0,  32'h0,         L, L, 32'h0,         L, L};

      drive_idle();
      do_reset();
      for (int i = 0; i < 16; i++) begin
         apply_stimulus(vecs[i]);
         @(negedge clk);
         check_output(i, vecs[i]);
         step();
      end

      // Both paths requesting continuously against a zero-wait memory.
      do_reset();
      auto_mem  = H;
      if_req    = H;
      if_addr   = 32'h200;
      d_req     = H;
      d_we      = L;
      d_addr    = 32'h300;
      order     = "";
      exp_order = "DDDDIDDDDI";
      cycles    = 0;
      while (order.len() < 10 && cycles < 100) begin
         @(negedge clk);
         check("streak stall_if", 32'(stall_if), 32'(!if_done));
         if (if_done) begin
            order = {order, "I"};
            check("streak if_rdata", if_rdata, 32'h200 ^ 32'hA5A5_0000);
         end
         if (d_done) begin
            order = {order, "D"};
            check("streak d_rdata", d_rdata, 32'h300 ^ 32'hA5A5_0000);
         end
         step();
         cycles++;
      end
      compared++;
      if (order != exp_order) begin
         mismatched++;
         $display("[TB] FAIL grant order: got %s, expected %s", order, exp_order);
      end
      auto_mem = L;
      drive_idle();

      // Reset lands in the second busy cycle of a data read.
      do_reset();
      d_req  = H;
      d_addr = 32'h80;
      step();
      @(negedge clk);
      check("midreset busy1 mem_req", 32'(mem_req), 32'(H));
      step();
      rst     = L;
      d_req   = L;
      if_req  = H;
      if_addr = 32'h500;
      @(negedge clk);
      check("midreset busy2 mem_req", 32'(mem_req), 32'(H));
      step();
      rst = H;
      @(negedge clk);
      check("midreset after mem_req", 32'(mem_req), 32'(L));
      check("midreset after d_done", 32'(d_done), 32'(L));
      step();
      @(negedge clk);
      check("midreset if grant mem_req", 32'(mem_req), 32'(H));
      check("midreset if grant mem_addr", mem_addr, 32'h500);
      check("midreset no late d_done", 32'(d_done), 32'(L));
      tb_ack   = H;
      tb_rdata = 32'h0BAD_F00D;
      step();
      tb_ack = L;
      if_req = L;
      @(negedge clk);
      check("midreset if_done", 32'(if_done), 32'(H));
      check("midreset if_rdata", if_rdata, 32'h0BAD_F00D);
      step();

`ifdef MEM_ARB_TIMEOUT_EN
      // Read with no ack: watchdog aborts after 8 request cycles.
      do_reset();
      d_req  = H;
      d_addr = 32'h60;
      busy_cycles = 0;
      seen_done   = L;
      for (int c = 0; c < 30 && !seen_done; c++) begin
         @(negedge clk);
         if (mem_req)
            busy_cycles++;
         if (d_done) begin
            seen_done = H;
            check("timeout err", 32'(timeout_err), 32'(H));
            check("timeout d_rdata", d_rdata, 32'h0);
            check("timeout mem_req cycles", 32'(busy_cycles), 32'd8);
            d_req = L;
         end else begin
            check("timeout err early", 32'(timeout_err), 32'(L));
         end
         step();
      end
      check("timeout done seen", 32'(seen_done), 32'(H));

      // Ack arriving on the limit edge wins over the watchdog.
      drive_idle();
      step();
      d_req  = H;
      d_addr = 32'h64;
      busy_cycles = 0;
      seen_done   = L;
      for (int c = 0; c < 30 && !seen_done; c++) begin
         tb_ack = L;
         if (mem_req) begin
            busy_cycles++;
            if (busy_cycles == 8) begin
               tb_ack   = H;
               tb_rdata = 32'h0000_0077;
            end
         end
         @(negedge clk);
         if (d_done) begin
            seen_done = H;
            check("limit ack timeout_err", 32'(timeout_err), 32'(L));
            check("limit ack d_rdata", d_rdata, 32'h0000_0077);
            d_req = L;
         end
         step();
      end
      check("limit ack done seen", 32'(seen_done), 32'(H));
      drive_idle();
`else
      busy_cycles = 0;
      seen_done   = L;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
